bf_program_loader: RTL
======================

// Module: bf_program_loader
// PURPOSE
//  Writer side of the BF program store: accepts an ASCII Brainfuck stream over a valid/ready
//  handshake, encodes each command to a 4-bit opcode, writes it to program memory at BCD
//  addresses (00,01..09,10..) and appends the 0000 terminator. Checks bracket balance and
//  capacity. Sits between the host/UART byte source and the program RAM read by the IP fetch.
// PARAMETERS
//  portSize   8   address width; multiple of 4, one BCD digit per nibble (8 -> 00..99)
//  dataSize   4   opcode width
//  DepthWidth 4   bracket-depth counter width; max nesting 2**DepthWidth-1
// PORTS
//  Clk        in   1          clock, rising edge
//  Rst_n      in   1          asynchronous reset, active low
//  Start      in   1          pulse: begin new load (honoured in IDLE/DONE/ERROR only)
//  Char       in   8          ASCII character
//  CharValid  in   1          Char valid
//  CharReady  out  1          loader accepts Char this cycle
//  Eot        in   1          end of text; sampled when CharReady=1, CharValid need not be set
//  WrAddr     out  portSize   BCD write address
//  WrData     out  dataSize   opcode to write
//  WrEn       out  1          one-cycle write strobe
//  Busy       out  1          state is LOAD or TERM
//  Done       out  1          load finished OK (level until Start)
//  Error      out  1          load aborted (level until Start)
//  ErrCode    out  2          01 ']' at depth 0; 10 Eot with depth!=0; 11 capacity/depth overflow
// BEHAVIOUR
//  Reset: state IDLE; WrAddr=0, WrData=0, WrEn=0, CharReady=0, Busy=0, Done=0, Error=0,
//   ErrCode=00, depth=0. Applies immediately, also mid-load; no partial write issued afterwards.
//  Encoding: '+'0001 '-'0010 '>'0011 '<'0100 '['0101 ']'0110 '.'0111 ','1000; terminator 0000.
//   Any other byte is consumed (handshake completes), no write, no address change.
//  States: IDLE -Start-> LOAD; LOAD -Eot-> TERM -> DONE; LOAD -fault-> ERROR;
//   DONE/ERROR -Start-> LOAD. Start clears WrAddr to 0, depth to 0, Done/Error/ErrCode.
//  CharReady = (state==LOAD); combinational from state. Transfer = CharValid & CharReady.
//  Latency: accepted command at edge N -> WrEn=1 with WrAddr/WrData during cycle N+1;
//   WrAddr then BCD-increments (digit 9 -> 0 with carry), visible from cycle N+2.
//   Throughput one command per cycle.
//  Depth: '[' +1, ']' -1. ']' at depth 0 -> ERROR, ErrCode 01, no write.
//   '[' at depth max -> ERROR, ErrCode 11, no write.
//  Capacity: last address (all digits 9) is reserved for terminator. A command arriving
//   when WrAddr is all-9s -> ERROR, ErrCode 11, no write.
//  Eot (in LOAD, regardless of CharValid): if a Char transfers in the same cycle it is
//   processed first (incl. faults; a fault wins and Eot is discarded). Then depth!=0 -> ERROR
//   ErrCode 10; else TERM: terminator 0000 written at the next free address one cycle after
//   the last command write (cycle N+1 if no char with Eot, N+2 if char with Eot), then DONE.
//  Empty program (Eot first): single write 0000 at 00, DONE.
//  ERROR/DONE: CharReady=0, WrEn=0; memory contents left as written.
//  Start while Busy: ignored. Start same cycle as Rst_n low: reset wins.
// TESTING
//  1 "+++[+++[+++]+++]+++" then Eot -> writes 00..09 = 1,1,1,5,1,1,1,5,1,1;
//    10..18 = 1,6,1,1,1,6,1,1,1; 0000 at 19; Done=1, Error=0.
//  2 "+a\n-" Eot -> only 00=0001, 01=0010, 02=0000; 'a','\n' consumed, CharReady stays 1.
//  3 "]" -> no write, Error=1 ErrCode=01, CharReady=0; Start then "+" Eot -> 00=1, 01=0, Done.
//  4 "[[+" Eot -> 00=5,01=5,02=1, no terminator, Error=1 ErrCode=10.
//  5 99 '+' -> 00..98 written, '+' 100th -> Error ErrCode 11; 99 '+' then Eot -> 99=0000, Done.
//  6 Rst_n low during LOAD while CharValid streaming -> WrEn=0, WrAddr=00, state IDLE same
//    cycle; CharReady=0 until Start.

Source files
------------

// File: rtl/bf_program_loader.sv
// bf_program_loader: writer side of the BF program store.
// Accepts an ASCII Brainfuck stream over a valid/ready handshake, encodes each command
// to a 4-bit opcode and writes it at consecutive BCD addresses, then appends the 0000
// terminator. Bracket balance and program capacity are checked while loading.
module bf_program_loader #(
  parameter int portSize   = 8,
  parameter int dataSize   = 4,
  parameter int DepthWidth = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [7:0]          i_char,
  input  logic                i_charValid,
  output logic                o_charReady,
  input  logic                i_eot,
  output logic [portSize-1:0] o_wrAddr,
  output logic [dataSize-1:0] o_wrData,
  output logic                o_wrEn,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [1:0]          o_errCode
);

  localparam int Digits = portSize / 4;
  localparam logic [3:0] OpOpen  = 4'b0101;
  localparam logic [3:0] OpClose = 4'b0110;
  localparam logic [DepthWidth-1:0] DepthMax = {DepthWidth{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TERM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  logic [portSize-1:0]   r_wrAddr;
  logic [dataSize-1:0]   r_wrData;
  logic                  r_wrEn;
  logic [DepthWidth-1:0] r_depth;
  logic [1:0]            r_errCode;

  state_t                w_stateNext;
  logic [portSize-1:0]   w_wrAddrNext;
  logic [dataSize-1:0]   w_wrDataNext;
  logic                  w_wrEnNext;
  logic [DepthWidth-1:0] w_depthNext;
  logic [1:0]            w_errCodeNext;
  logic [portSize-1:0]   w_freeAddr;
  logic [3:0]            w_op;
  logic                  w_xfer;
  logic                  w_fault;

  // Add one to a multi-digit BCD number; each nibble wraps 9 -> 0 and carries upward.
  function automatic logic [portSize-1:0] bcdInc(input logic [portSize-1:0] a);
    logic [portSize-1:0] r;
    logic                carry;
    r     = a;
    carry = 1'b1;
    for (int i = 0; i < Digits; i++) begin
      if (carry) begin
        if (a[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = a[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // True when every BCD digit is 9: the slot kept free for the terminator.
  function automatic logic isLastAddr(input logic [portSize-1:0] a);
    logic allNine;
    allNine = 1'b1;
    for (int i = 0; i < Digits; i++) begin
      if (a[i*4 +: 4] != 4'd9) allNine = 1'b0;
    end
    return allNine;
  endfunction

  // Brainfuck command to opcode; zero means "not a command, consume silently".
  function automatic logic [3:0] encode(input logic [7:0] c);
    logic [3:0] op;
    case (c)
      8'h2B:   op = 4'b0001;
      8'h2D:   op = 4'b0010;
      8'h3E:   op = 4'b0011;
      8'h3C:   op = 4'b0100;
      8'h5B:   op = OpOpen;
      8'h5D:   op = OpClose;
      8'h2E:   op = 4'b0111;
      8'h2C:   op = 4'b1000;
      default: op = 4'b0000;
    endcase
    return op;
  endfunction

  assign o_charReady = (r_state == S_LOAD);
  assign w_xfer      = i_charValid & o_charReady;
  assign w_op        = encode(i_char);
  // A write in flight bumps the address at the coming edge, so the next free slot is one further.
  assign w_freeAddr  = r_wrEn ? bcdInc(r_wrAddr) : r_wrAddr;

  assign o_wrAddr  = r_wrAddr;
  assign o_wrData  = r_wrData;
  assign o_wrEn    = r_wrEn;
  assign o_busy    = (r_state == S_LOAD) || (r_state == S_TERM);
  assign o_done    = (r_state == S_DONE);
  assign o_error   = (r_state == S_ERROR);
  assign o_errCode = r_errCode;

  // Next-state, write strobe, depth tracking and fault detection.
  always_comb begin
    w_stateNext   = r_state;
    w_wrAddrNext  = w_freeAddr;
    w_wrDataNext  = r_wrData;
    w_wrEnNext    = 1'b0;
    w_depthNext   = r_depth;
    w_errCodeNext = r_errCode;
    w_fault       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_stateNext   = S_LOAD;
          w_wrAddrNext  = '0;
          w_depthNext   = '0;
          w_errCodeNext = 2'b00;
        end
      end
      S_LOAD: begin
        if (w_xfer && (w_op != 4'b0000)) begin
          if ((w_op == OpClose) && (r_depth == '0)) begin
            w_fault       = 1'b1;
            w_errCodeNext = 2'b01;
          end else if ((w_op == OpOpen) && (r_depth == DepthMax)) begin
            w_fault       = 1'b1;
            w_errCodeNext = 2'b11;
          end else if (isLastAddr(w_freeAddr)) begin
            w_fault       = 1'b1;
            w_errCodeNext = 2'b11;
          end else begin
            w_wrEnNext   = 1'b1;
            w_wrDataNext = dataSize'(w_op);
            if (w_op == OpOpen)  w_depthNext = r_depth + DepthWidth'(1);
            if (w_op == OpClose) w_depthNext = r_depth - DepthWidth'(1);
          end
        end
        if (w_fault) begin
          w_stateNext = S_ERROR;
          w_wrEnNext  = 1'b0;
        end else if (i_eot) begin
          if (w_depthNext != '0) begin
            w_stateNext   = S_ERROR;
            w_errCodeNext = 2'b10;
            w_wrEnNext    = 1'b0;
          end else begin
            w_stateNext = S_TERM;
            if (!w_wrEnNext) begin
              w_wrEnNext   = 1'b1;
              w_wrDataNext = '0;
            end
          end
        end
      end
      S_TERM: begin
        if (r_wrEn && (r_wrData == '0)) begin
          w_stateNext = S_DONE;
        end else begin
          w_wrEnNext   = 1'b1;
          w_wrDataNext = '0;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // State and write-port registers; reset drops any pending write immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
      r_wrEn    <= 1'b0;
      r_depth   <= '0;
      r_errCode <= 2'b00;
    end else begin
      r_state   <= w_stateNext;
      r_wrAddr  <= w_wrAddrNext;
      r_wrData  <= w_wrDataNext;
      r_wrEn    <= w_wrEnNext;
      r_depth   <= w_depthNext;
      r_errCode <= w_errCodeNext;
    end
  end

endmodule
